// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared constants and FSM state encoding for the BCD
//                digit-serial subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_BASE      = 10;
    localparam int BCD_DIGIT_MAX = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_NEG  = 2'd2,
        ST_DONE = 2'd3
    } bcd_state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_sub.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_sub
//  Description : Combinational single-digit BCD subtract: d = a - b - bin.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   bin,
    output logic [BCD_DIGIT_W-1:0] d,
    output logic                   bout,
    output logic                   digit_invalid
);

    // One extra bit so the raw difference carries its sign in the MSB
    logic [BCD_DIGIT_W:0] w_t;

    assign w_t  = {1'b0, a} - {1'b0, b} - {{BCD_DIGIT_W{1'b0}}, bin};
    assign bout = w_t[BCD_DIGIT_W];
    assign d    = bout ? (w_t[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_BASE))
                       : w_t[BCD_DIGIT_W-1:0];

    assign digit_invalid = (a > BCD_DIGIT_W'(BCD_DIGIT_MAX)) ||
                           (b > BCD_DIGIT_W'(BCD_DIGIT_MAX));

endmodule
`default_nettype wire

// File: rtl/bcd_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_serial_subtractor
//  Description : Digit-serial packed-BCD subtractor, LSD first, one digit per
//                clock under a start/done handshake. Optional sign-magnitude
//                output via macro BCD_SUB_SIGN_MAGNITUDE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   minuend,
    input  logic [4*DIGITS-1:0]   subtrahend,
    input  logic                  borrow_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   difference,
    output logic                  borrow_out,
    output logic                  invalid
`ifdef BCD_SUB_SIGN_MAGNITUDE_EN
    ,
    output logic                  negative
`endif
);

    localparam int c_w     = BCD_DIGIT_W * DIGITS;
    localparam int c_cnt_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIGITS - 1);

    bcd_state_t r_state, w_state_next;

    logic [c_w-1:0]         r_a, r_b, r_acc, r_diff;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_brw, r_inv, r_bout, r_invalid;
    logic [BCD_DIGIT_W-1:0] w_d;
    logic                   w_bout, w_dig_inv, w_last, w_accept, w_inv_f;
    logic [c_w+3:0]         w_cat;
    logic [c_w-1:0]         w_res;

    bcd_digit_sub u_digit (
        .a             (r_a[BCD_DIGIT_W-1:0]),
        .b             (r_b[BCD_DIGIT_W-1:0]),
        .bin           (r_brw),
        .d             (w_d),
        .bout          (w_bout),
        .digit_invalid (w_dig_inv)
    );

    assign busy     = (r_state == ST_SUB) || (r_state == ST_NEG);
    assign done     = (r_state == ST_DONE);
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_cnt == c_last);
    assign w_inv_f  = r_inv | w_dig_inv;
    // New digit enters at the top; after DIGITS steps the word is in order
    assign w_cat    = {w_d, r_acc};
    assign w_res    = w_cat[c_w+3:4];

`ifdef BCD_SUB_SIGN_MAGNITUDE_EN
    logic w_go_neg;
    logic r_neg;
    assign w_go_neg = w_bout & ~w_inv_f;
    assign negative = r_neg;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_SUB;
`ifdef BCD_SUB_SIGN_MAGNITUDE_EN
            ST_SUB:  if (w_last) w_state_next = w_go_neg ? ST_NEG : ST_DONE;
            ST_NEG:  if (w_last) w_state_next = ST_DONE;
`else
            ST_SUB:  if (w_last) w_state_next = ST_DONE;
`endif
            ST_DONE: w_state_next = start ? ST_SUB : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_diff    <= '0;
            r_cnt     <= '0;
            r_brw     <= 1'b0;
            r_inv     <= 1'b0;
            r_bout    <= 1'b0;
            r_invalid <= 1'b0;
`ifdef BCD_SUB_SIGN_MAGNITUDE_EN
            r_neg     <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a   <= minuend;
            r_b   <= subtrahend;
            r_brw <= borrow_in;
            r_cnt <= '0;
            r_inv <= 1'b0;
        end else if (busy) begin
            r_a   <= r_a >> BCD_DIGIT_W;
            r_b   <= r_b >> BCD_DIGIT_W;
            r_brw <= w_bout;
            r_acc <= w_res;
            r_inv <= w_inv_f;
            r_cnt <= w_last ? '0 : r_cnt + c_cnt_w'(1);
            if (w_last) begin
`ifdef BCD_SUB_SIGN_MAGNITUDE_EN
                if (r_state == ST_NEG) begin
                    r_diff    <= w_res;
                    r_bout    <= 1'b1;
                    r_invalid <= 1'b0;
                    r_neg     <= 1'b1;
                end else if (w_go_neg) begin
                    // Second pass: 0 - R gives the magnitude of the result
                    r_a   <= '0;
                    r_b   <= w_res;
                    r_brw <= 1'b0;
                end else begin
                    r_diff    <= w_inv_f ? '0 : w_res;
                    r_bout    <= w_bout & ~w_inv_f;
                    r_invalid <= w_inv_f;
                    r_neg     <= 1'b0;
                end
`else
                r_diff    <= w_inv_f ? '0 : w_res;
                r_bout    <= w_bout & ~w_inv_f;
                r_invalid <= w_inv_f;
`endif
            end
        end
    end

    assign difference = r_diff;
    assign borrow_out = r_bout;
    assign invalid    = r_invalid;

endmodule
`default_nettype wire
